// File: rtl/cnn_core_stream_adapter_pkg.sv
// Shared cnn_core dimensions, adapter state encoding and a clog2 helper
// used by the stream adapter and its result reducer.
package cnn_core_stream_adapter_pkg;

    localparam int CNN_CI         = 2;
    localparam int CNN_KX         = 3;
    localparam int CNN_KY         = 3;
    localparam int CNN_CO         = 4;
    localparam int CNN_I_FM_BW    = 8;
    localparam int CNN_O_F_BW     = 20;
    localparam int CNN_O_F_ACC_BW = 22;
    localparam int CNN_LOAD_MODE  = 1;
    localparam int CNN_N          = CNN_CI * CNN_KX * CNN_KY;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_FIRE   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } adapter_state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cnn_core_stream_adapter_reducer.sv
// CO-way adder over the core output slices; each slice is zero-extended
// and the sum wraps modulo 2^O_F_ACC_BW.
module cnn_result_reducer
    import cnn_core_stream_adapter_pkg::*;
#(
    parameter int CO         = CNN_CO,
    parameter int O_F_BW     = CNN_O_F_BW,
    parameter int O_F_ACC_BW = CNN_O_F_ACC_BW
) (
    input  logic [CO*O_F_BW-1:0]   i_fmap,
    output logic [O_F_ACC_BW-1:0]  o_sum
);

    always_comb begin
        o_sum = '0;
        for (int c = 0; c < CO; c++) begin
            o_sum = o_sum + O_F_ACC_BW'(i_fmap[c*O_F_BW +: O_F_BW]);
        end
    end

endmodule

// File: rtl/cnn_core_stream_adapter.sv
// Assembles an input window from a serial stream, fires it to cnn_core,
// and returns channel 0 plus the cross-channel sum over a valid/ready port.
module cnn_core_stream_adapter
    import cnn_core_stream_adapter_pkg::*;
#(
    parameter int CI         = CNN_CI,
    parameter int KX         = CNN_KX,
    parameter int KY         = CNN_KY,
    parameter int CO         = CNN_CO,
    parameter int I_FM_BW    = CNN_I_FM_BW,
    parameter int O_F_BW     = CNN_O_F_BW,
    parameter int O_F_ACC_BW = CNN_O_F_ACC_BW,
    parameter int LOAD_MODE  = CNN_LOAD_MODE
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_soft_reset,
    input  logic                          i_load_valid,
    output logic                          o_load_ready,
    input  logic [I_FM_BW-1:0]            i_load_data,
    output logic                          o_core_valid,
    output logic [CI*KX*KY*I_FM_BW-1:0]   o_core_fmap,
    input  logic                          i_core_valid,
    input  logic [CO*O_F_BW-1:0]          i_core_fmap,
    output logic                          o_res_valid,
    input  logic                          i_res_ready,
    output logic [O_F_BW-1:0]             o_res_ch0,
    output logic [O_F_ACC_BW-1:0]         o_res_acc,
    output logic                          o_busy,
    output logic                          o_err_unexp
);

    localparam int N     = CI * KX * KY;
    localparam int CNT_W = (N > 1) ? clog2(N) : 1;
    localparam int WIN_W = N * I_FM_BW;

    adapter_state_e         state_q, state_d;
    logic [CNT_W-1:0]       tapCnt_q, tapCnt_d;
    logic [WIN_W-1:0]       window_q, window_d;
    logic [O_F_BW-1:0]      resCh0_q, resCh0_d;
    logic [O_F_ACC_BW-1:0]  resAcc_q, resAcc_d;
    logic                   errUnexp_q, errUnexp_d;
    logic [O_F_ACC_BW-1:0]  coreSum;

    cnn_result_reducer #(
        .CO         (CO),
        .O_F_BW     (O_F_BW),
        .O_F_ACC_BW (O_F_ACC_BW)
    ) u_reducer (
        .i_fmap (i_core_fmap),
        .o_sum  (coreSum)
    );

    always_comb begin
        state_d    = state_q;
        tapCnt_d   = tapCnt_q;
        window_d   = window_q;
        resCh0_d   = resCh0_q;
        resAcc_d   = resAcc_q;
        errUnexp_d = errUnexp_q;

        unique case (state_q)
            ST_LOAD: begin
                if (i_load_valid) begin
                    if (LOAD_MODE == 0) begin
                        window_d = {N{i_load_data}};
                        state_d  = ST_FIRE;
                    end else begin
                        window_d[tapCnt_q*I_FM_BW +: I_FM_BW] = i_load_data;
                        if (tapCnt_q == CNT_W'(N - 1)) begin
                            tapCnt_d = '0;
                            state_d  = ST_FIRE;
                        end else begin
                            tapCnt_d = tapCnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_FIRE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_core_valid) begin
                    resCh0_d = i_core_fmap[0 +: O_F_BW];
                    resAcc_d = coreSum;
                    state_d  = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (i_res_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        // A core response is only meaningful while a window is outstanding.
        if (i_core_valid && (state_q != ST_WAIT)) begin
            errUnexp_d = 1'b1;
        end

        if (i_soft_reset) begin
            state_d    = ST_LOAD;
            tapCnt_d   = '0;
            window_d   = '0;
            resCh0_d   = '0;
            resAcc_d   = '0;
            errUnexp_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_LOAD;
            tapCnt_q   <= '0;
            window_q   <= '0;
            resCh0_q   <= '0;
            resAcc_q   <= '0;
            errUnexp_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tapCnt_q   <= tapCnt_d;
            window_q   <= window_d;
            resCh0_q   <= resCh0_d;
            resAcc_q   <= resAcc_d;
            errUnexp_q <= errUnexp_d;
        end
    end

    assign o_load_ready = (state_q == ST_LOAD);
    assign o_core_valid = (state_q == ST_FIRE);
    assign o_res_valid  = (state_q == ST_RESULT);
    assign o_busy       = (state_q != ST_LOAD);
    assign o_core_fmap  = window_q;
    assign o_res_ch0    = resCh0_q;
    assign o_res_acc    = resAcc_q;
    assign o_err_unexp  = errUnexp_q;

endmodule

// File: tb/tb_cnn_core_stream_adapter.sv
// Directed bench: per-tap adapter at 22- and 21-bit accumulator widths
// sharing one stimulus stream, plus a broadcast-mode adapter.
module tb_cnn_core_stream_adapter;

    localparam int N = 18;

    logic clk = 1'b0;
    logic reset_n;
    logic softReset;
    logic loadValid;
    logic [7:0] loadData;
    logic coreValid;
    logic [79:0] coreFmap;
    logic resReady;

    logic cLoadValid;
    logic [7:0] cLoadData;
    logic cCoreValid;
    logic cResReady;

    logic aLoadReady, aCoreValid, aResValid, aBusy, aErr;
    logic [143:0] aFmap;
    logic [19:0] aCh0;
    logic [21:0] aAcc;

    logic bLoadReady, bCoreValid, bResValid, bBusy, bErr;
    logic [143:0] bFmap;
    logic [19:0] bCh0;
    logic [20:0] bAcc;

    logic cLoadReady, cCoreValidO, cResValid, cBusy, cErr;
    logic [143:0] cFmap;
    logic [19:0] cCh0;
    logic [21:0] cAcc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnn_core_stream_adapter #(.O_F_ACC_BW(22), .LOAD_MODE(1)) dutA (
        .clk(clk), .reset_n(reset_n), .i_soft_reset(softReset),
        .i_load_valid(loadValid), .o_load_ready(aLoadReady), .i_load_data(loadData),
        .o_core_valid(aCoreValid), .o_core_fmap(aFmap),
        .i_core_valid(coreValid), .i_core_fmap(coreFmap),
        .o_res_valid(aResValid), .i_res_ready(resReady),
        .o_res_ch0(aCh0), .o_res_acc(aAcc), .o_busy(aBusy), .o_err_unexp(aErr)
    );

    cnn_core_stream_adapter #(.O_F_ACC_BW(21), .LOAD_MODE(1)) dutB (
        .clk(clk), .reset_n(reset_n), .i_soft_reset(softReset),
        .i_load_valid(loadValid), .o_load_ready(bLoadReady), .i_load_data(loadData),
        .o_core_valid(bCoreValid), .o_core_fmap(bFmap),
        .i_core_valid(coreValid), .i_core_fmap(coreFmap),
        .o_res_valid(bResValid), .i_res_ready(resReady),
        .o_res_ch0(bCh0), .o_res_acc(bAcc), .o_busy(bBusy), .o_err_unexp(bErr)
    );

    cnn_core_stream_adapter #(.O_F_ACC_BW(22), .LOAD_MODE(0)) dutC (
        .clk(clk), .reset_n(reset_n), .i_soft_reset(softReset),
        .i_load_valid(cLoadValid), .o_load_ready(cLoadReady), .i_load_data(cLoadData),
        .o_core_valid(cCoreValidO), .o_core_fmap(cFmap),
        .i_core_valid(cCoreValid), .i_core_fmap(coreFmap),
        .o_res_valid(cResValid), .i_res_ready(cResReady),
        .o_res_ch0(cCh0), .o_res_acc(cAcc), .o_busy(cBusy), .o_err_unexp(cErr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Streams count per-tap beats starting at firstValue, one per cycle.
    task automatic applyStimulus(input int firstValue, input int count);
        for (int k = 0; k < count; k++) begin
            loadValid = 1'b1;
            loadData  = 8'(firstValue + k);
            tick();
            if (k < count - 1) begin
                checkOutput("no_early_core_valid", 64'(aCoreValid), 64'd0);
            end
        end
        loadValid = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        softReset  = 1'b0;
        loadValid  = 1'b0;
        loadData   = '0;
        coreValid  = 1'b0;
        coreFmap   = '0;
        resReady   = 1'b0;
        cLoadValid = 1'b0;
        cLoadData  = '0;
        cCoreValid = 1'b0;
        cResReady  = 1'b0;

        repeat (2) tick();
        checkOutput("reset_load_ready", 64'(aLoadReady), 64'd1);
        checkOutput("reset_core_valid", 64'(aCoreValid), 64'd0);
        checkOutput("reset_res_valid", 64'(aResValid), 64'd0);
        checkOutput("reset_busy", 64'(aBusy), 64'd0);
        checkOutput("reset_err", 64'(aErr), 64'd0);
        checkOutput("reset_fmap_low", aFmap[63:0], 64'd0);
        checkOutput("reset_acc", 64'(aAcc), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Per-tap load of 1..18
        loadValid = 1'b1;
        loadData  = 8'd1;
        for (int k = 0; k < N; k++) begin
            loadData = 8'(k + 1);
            tick();
            if (k < N - 1) begin
                checkOutput("pertap_no_early_valid", 64'(aCoreValid), 64'd0);
            end
        end
        checkOutput("pertap_core_valid", 64'(aCoreValid), 64'd1);
        checkOutput("pertap_load_ready_fire", 64'(aLoadReady), 64'd0);
        checkOutput("pertap_busy", 64'(aBusy), 64'd1);
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("pertap_tap%0d", k), 64'(aFmap[k*8 +: 8]), 64'(k + 1));
        end
        tick();
        loadValid = 1'b0;
        checkOutput("wait_core_valid_drop", 64'(aCoreValid), 64'd0);
        checkOutput("wait_load_ready", 64'(aLoadReady), 64'd0);
        checkOutput("wait_fmap_tap17", 64'(aFmap[17*8 +: 8]), 64'd18);

        // Core returns {40,30,20,10}
        coreValid = 1'b1;
        coreFmap  = {20'd40, 20'd30, 20'd20, 20'd10};
        tick();
        coreValid = 1'b0;
        checkOutput("result_valid", 64'(aResValid), 64'd1);
        checkOutput("result_ch0", 64'(aCh0), 64'd10);
        checkOutput("result_acc", 64'(aAcc), 64'd100);
        checkOutput("result_acc_21", 64'(bAcc), 64'd100);
        checkOutput("result_no_err", 64'(aErr), 64'd0);

        // Backpressure for five cycles
        coreFmap = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_res_valid", 64'(aResValid), 64'd1);
            checkOutput("bp_ch0", 64'(aCh0), 64'd10);
            checkOutput("bp_acc", 64'(aAcc), 64'd100);
            checkOutput("bp_load_ready", 64'(aLoadReady), 64'd0);
        end
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        checkOutput("hs_res_valid_drop", 64'(aResValid), 64'd0);
        checkOutput("hs_load_ready", 64'(aLoadReady), 64'd1);

        // Accumulator width limit
        applyStimulus(20, N);
        checkOutput("width_core_valid", 64'(aCoreValid), 64'd1);
        tick();
        coreValid = 1'b1;
        coreFmap  = {4{20'hFFFFF}};
        tick();
        coreValid = 1'b0;
        checkOutput("width_ch0", 64'(aCh0), 64'h000FFFFF);
        checkOutput("width_acc22", 64'(aAcc), 64'd4194300);
        checkOutput("width_acc21_wrap", 64'(bAcc), 64'd2097148);
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        checkOutput("width_back_to_load", 64'(aLoadReady), 64'd1);

        // Unexpected core valid while loading
        coreValid = 1'b1;
        coreFmap  = {20'd1, 20'd2, 20'd3, 20'd4};
        tick();
        coreValid = 1'b0;
        checkOutput("err_set", 64'(aErr), 64'd1);
        checkOutput("err_no_result", 64'(aResValid), 64'd0);
        checkOutput("err_still_load", 64'(aLoadReady), 64'd1);
        checkOutput("err_acc_untouched", 64'(aAcc), 64'd4194300);
        applyStimulus(60, N);
        checkOutput("err_load_continues", 64'(aCoreValid), 64'd1);
        checkOutput("err_tap0", 64'(aFmap[7:0]), 64'd60);
        checkOutput("err_sticky", 64'(aErr), 64'd1);
        tick();
        softReset = 1'b1;
        tick();
        softReset = 1'b0;
        checkOutput("soft_clear_err", 64'(aErr), 64'd0);
        checkOutput("soft_load_ready", 64'(aLoadReady), 64'd1);
        checkOutput("soft_busy", 64'(aBusy), 64'd0);
        checkOutput("soft_fmap_clear", aFmap[63:0], 64'd0);
        checkOutput("soft_acc_clear", 64'(aAcc), 64'd0);

        // Soft reset after seven beats, then a fresh window 100..117
        applyStimulus(50, 7);
        softReset = 1'b1;
        tick();
        softReset = 1'b0;
        checkOutput("midload_load_ready", 64'(aLoadReady), 64'd1);
        applyStimulus(100, N);
        checkOutput("midload_core_valid", 64'(aCoreValid), 64'd1);
        checkOutput("midload_tap0", 64'(aFmap[7:0]), 64'd100);
        checkOutput("midload_tap6", 64'(aFmap[6*8 +: 8]), 64'd106);
        checkOutput("midload_tap17", 64'(aFmap[17*8 +: 8]), 64'd117);

        // Broadcast mode single beat
        checkOutput("bcast_ready_before", 64'(cLoadReady), 64'd1);
        cLoadValid = 1'b1;
        cLoadData  = 8'h5A;
        tick();
        cLoadValid = 1'b0;
        checkOutput("bcast_core_valid", 64'(cCoreValidO), 64'd1);
        checkOutput("bcast_load_ready", 64'(cLoadReady), 64'd0);
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("bcast_tap%0d", k), 64'(cFmap[k*8 +: 8]), 64'h5A);
        end
        tick();
        checkOutput("bcast_core_valid_drop", 64'(cCoreValidO), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
